machine_csr_unit: RTL and testbench
===================================

MACHINE_CSR_UNIT -- requirements
Module: machine_csr_unit

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 64, width of mcycle/minstret/mhpmcounter (legal values 32 or 64).
REQ-002 SHALL have parameter NUM_HPM, default 4, number of hardware performance counters (0..29), mapped to mhpmcounter3 upward.
REQ-003 SHALL have parameter VECTORED_EN, default 1; 1 honours mtvec.MODE=1, 0 forces MODE to read 0.
REQ-004 clock  input  1  clock; all state updates on posedge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 csrAddr  input  12  CSR address.
REQ-007 csrOp  input  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
REQ-008 csrWdata  input  32  write/mask operand.
REQ-009 csrRdata  output  32  combinational read of csrAddr, pre-update value.
REQ-010 csrIllegal  output  1  csrOp!=00 and the address is unimplemented, or the op is a write to a read-only CSR.
REQ-011 retire  input  1  one instruction retired this cycle.
REQ-012 hpmEvent  input  NUM_HPM  per-counter increment strobe.
REQ-013 swIrq, timerIrq, extIrq  input  1 each  level interrupt sources (mip bits 3, 7, 11).
REQ-014 trapReq  input  1  synchronous exception detected, held until accepted.
REQ-015 trapCause  input  5  exception code.
REQ-016 trapPC, trapVal  input  32 each  faulting PC and mtval value.
REQ-017 wbValid  input  1  the faulting instruction has reached writeback.
REQ-018 mret  input  1  MRET at writeback.
REQ-019 redirectValid  output  1  one-cycle pulse: the pipeline shall flush and fetch redirectPC.
REQ-020 redirectPC  output  32  trap target or mepc.
REQ-021 irqPending  output  1  mstatus.MIE & |(mip & mie).

Function
REQ-022 FSM states: RUN, PENDING, REDIRECT; reset enters RUN.
REQ-023 RUN->PENDING when trapReq=1 and wbValid=0; RUN->REDIRECT on trapReq&wbValid, or on irqPending&wbValid.
REQ-024 PENDING latches cause, PC and value on entry, ignores later trapReq, and goes to REDIRECT on the first cycle with wbValid=1.
REQ-025 On the RUN/PENDING->REDIRECT edge the unit SHALL commit the trap:
  - mepc <= PC; mcause <= {irq,26'b0,code}; mtval <= value, or 0 for an interrupt
  - MPIE <= MIE; MIE <= 0
REQ-026 REDIRECT asserts redirectValid for one cycle and then returns to RUN.
REQ-027 redirectPC = {mtvec[31:2],2'b00}, plus 4*code when the cause is an interrupt and the effective MODE=1; for MRET it is mepc.
REQ-028 A synchronous exception has priority over an interrupt in the same cycle; interrupt code priority is ext(11) > sw(3) > timer(7).
REQ-029 mret in RUN: MIE <= MPIE; MPIE <= 1; redirectValid pulses the next cycle with redirectPC=mepc.
REQ-030 Same-cycle priority: trap commit > mret > CSR write; a CSR write in a commit or mret cycle is dropped.
REQ-031 RS writes old|wdata, RC writes old&~wdata; RS/RC with wdata=0 performs no write and is never illegal.
REQ-032 Counters increment every cycle (mcycle), on retire (minstret), and on hpmEvent[i] (mhpmcounter i), unless inhibited by mcountinhibit[bit] or written the same cycle.
REQ-033 Counters wrap to 0 at 2^COUNTER_WIDTH-1; the low-half carry propagates into the high half in the same cycle.
REQ-034 High-half addresses (0xB80+) are illegal when COUNTER_WIDTH=32.
REQ-035 Writes to one half leave the other half unchanged.
REQ-036 mip is read-only: it mirrors the input levels, registered one cycle.
REQ-037 misa is read-only, value 0x40000100; writes to it flag csrIllegal.
REQ-038 WARL masks:
  - mstatus: only bits 3, 7 and 12:11 are writable
  - MPP reads 2'b11
  - mie: only bits 3, 7 and 11 are writable
  - mtvec: bit 1 reads 0

Reset
REQ-039 reset SHALL clear every CSR and counter, set mstatus=0x00001800, set the state to RUN, and drive redirectValid=0, redirectPC=0 and irqPending=0 on the next cycle.
REQ-040 reset asserted in PENDING or REDIRECT SHALL abandon the trap without any CSR update.

Structure
REQ-041 csr_pkg SHALL hold the CSR address constants, the csrOp enum, the fsm state enum, cause codes, the MISA value and the mstatus bit indices.
REQ-042 One sub-module csr_counter (width-parameterised, with increment, inhibit, lo/hi write ports and wrap) SHALL be instantiated NUM_HPM+2 times.

Verification
REQ-043 Reset, then read 0x300 and 0x301 -> 0x00001800 and 0x40000100.
REQ-044 RS on 0x304 with 0x888, then RC with 0x8 -> mie=0x880; a write to 0x301 -> csrIllegal=1 and misa unchanged.
REQ-045 mtvec=0x1001, mstatus.MIE=1, mie=0x800, extIrq=1, wbValid=1 -> one redirectValid pulse with redirectPC=0x102C, mcause=0x8000000B, MIE=0, MPIE=1.
REQ-046 trapReq with cause 2, trapPC=0x200, trapVal=0xDEAD, wbValid low for 3 cycles then high -> mepc=0x200, mtval=0xDEAD, one redirect to mtvec base; then mret -> redirectPC=0x200 and MIE restored.
REQ-047 mcycle low word = 0xFFFFFFFF with the high word = 0 -> next cycle low = 0 and high = 1; with mcountinhibit[0]=1, mcycle is held.
REQ-048 reset asserted in PENDING -> no redirectValid pulse, and mepc stays 0.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, op/state enums, cause codes and mstatus layout
// for the machine-mode CSR unit.
package csr_pkg;
   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MIE           = 12'h304;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MTVAL         = 12'h343;
   localparam logic [11:0] CSR_MIP           = 12'h344;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [31:0] MISA_VALUE        = 32'h4000_0100;
   localparam logic [31:0] MIE_MASK          = 32'h0000_0888;
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam logic [4:0] IRQ_SW    = 5'd3;
   localparam logic [4:0] IRQ_TIMER = 5'd7;
   localparam logic [4:0] IRQ_EXT   = 5'd11;
   typedef enum logic [1:0] {OP_NONE, OP_RW, OP_RS, OP_RC} csr_op_e;
   typedef enum logic [1:0] {ST_RUN, ST_PENDING, ST_REDIRECT} state_e;
   // Counter k sits at address offset 0 (mcycle), 2 (minstret), 3.. (hpm).
   function automatic logic [4:0] counter_offset(input int k);
      return (k == 0) ? 5'd0 : 5'(k + 1);
   endfunction
endpackage

// File: rtl/csr_counter.sv
// csr_counter: wrapping event counter with inhibit and independent 32-bit
// low/high write ports; a write takes precedence over the increment.
module csr_counter #(
   parameter int WIDTH = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inc,
   input  logic        inhibit,
   input  logic        lo_we,
   input  logic        hi_we,
   input  logic [31:0] wdata,
   output logic [31:0] value_lo,
   output logic [31:0] value_hi
);
   logic [WIDTH-1:0] count, written;
   generate
      if (WIDTH > 32) begin : g_wide
         assign written  = {hi_we ? wdata : count[WIDTH-1:32], lo_we ? wdata : count[31:0]};
         assign value_hi = count[WIDTH-1:32];
      end else begin : g_narrow
         // No high half exists; the owner never raises hi_we here.
         assign written  = (lo_we | hi_we) ? wdata : count;
         assign value_hi = '0;
      end
   endgenerate
   assign value_lo = count[31:0];
   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (lo_we | hi_we)
         count <= written;
      else if (inc & ~inhibit)
         count <= count + WIDTH'(1);
   end
endmodule

// File: rtl/machine_csr_unit.sv
// machine_csr_unit: machine-mode CSR file with counters, interrupt/exception
// trap sequencing and MRET redirect.
module machine_csr_unit
   import csr_pkg::*;
#(
   parameter int COUNTER_WIDTH = 64,
   parameter int NUM_HPM       = 4,
   parameter int VECTORED_EN   = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [11:0]        csrAddr,
   input  logic [1:0]         csrOp,
   input  logic [31:0]        csrWdata,
   output logic [31:0]        csrRdata,
   output logic               csrIllegal,
   input  logic               retire,
   input  logic [NUM_HPM-1:0] hpmEvent,
   input  logic               swIrq,
   input  logic               timerIrq,
   input  logic               extIrq,
   input  logic               trapReq,
   input  logic [4:0]         trapCause,
   input  logic [31:0]        trapPC,
   input  logic [31:0]        trapVal,
   input  logic               wbValid,
   input  logic               mret,
   output logic               redirectValid,
   output logic [31:0]        redirectPC,
   output logic               irqPending
);
   localparam int NUM_CNT = NUM_HPM + 2;
   state_e state, state_next;
   csr_op_e op;
   logic mie_bit, mpie_bit;
   logic [31:0] mie_reg, mtvec, mcountinhibit, mscratch, mepc, mcause, mtval, mip;
   logic [31:0] redirect_pc_q, pend_pc, pend_val;
   logic [4:0] pend_cause;
   logic [31:0] mstatus, old, wr_data, irq_bits, commit_pc, commit_val, trap_target;
   logic [4:0] irq_code, commit_code;
   logic is_write, impl, read_only, csr_we, commit, commit_irq, take_mret, latch;
   logic [NUM_CNT-1:0] cnt_inc, cnt_lo_hit, cnt_hi_hit;
   logic [31:0] cnt_lo [NUM_CNT];
   logic [31:0] cnt_hi [NUM_CNT];
   assign op       = csr_op_e'(csrOp);
   assign mstatus  = {19'b0, 2'b11, 3'b0, mpie_bit, 3'b0, mie_bit, 3'b0};
   assign irq_bits = mip & mie_reg;
   assign irq_code = irq_bits[11] ? IRQ_EXT : irq_bits[3] ? IRQ_SW : IRQ_TIMER;
   assign irqPending    = mie_bit & |irq_bits;
   assign redirectValid = state == ST_REDIRECT;
   assign redirectPC    = redirect_pc_q;
   assign cnt_inc[0] = 1'b1;
   assign cnt_inc[1] = retire;
   generate
      if (NUM_HPM > 0) begin : g_hpm_inc
         assign cnt_inc[NUM_CNT-1:2] = hpmEvent;
      end
      for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
         assign cnt_lo_hit[k] = csrAddr == CSR_MCYCLE + 12'(counter_offset(k));
         assign cnt_hi_hit[k] = (COUNTER_WIDTH == 64) && (csrAddr == CSR_MCYCLEH + 12'(counter_offset(k)));
         csr_counter #(.WIDTH(COUNTER_WIDTH)) u_counter (
            .clock    (clock),
            .reset    (reset),
            .inc      (cnt_inc[k]),
            .inhibit  (mcountinhibit[counter_offset(k)]),
            .lo_we    (csr_we & cnt_lo_hit[k]),
            .hi_we    (csr_we & cnt_hi_hit[k]),
            .wdata    (wr_data),
            .value_lo (cnt_lo[k]),
            .value_hi (cnt_hi[k])
         );
      end
   endgenerate
   always_comb begin
      old       = '0;
      impl      = 1'b1;
      read_only = 1'b0;
      case (csrAddr)
         CSR_MSTATUS:       old = mstatus;
         CSR_MISA:          begin old = MISA_VALUE; read_only = 1'b1; end
         CSR_MIE:           old = mie_reg;
         CSR_MTVEC:         old = mtvec;
         CSR_MCOUNTINHIBIT: old = mcountinhibit;
         CSR_MSCRATCH:      old = mscratch;
         CSR_MEPC:          old = mepc;
         CSR_MCAUSE:        old = mcause;
         CSR_MTVAL:         old = mtval;
         CSR_MIP:           begin old = mip; read_only = 1'b1; end
         default: begin
            impl = |{cnt_lo_hit, cnt_hi_hit};
            for (int k = 0; k < NUM_CNT; k++)
               old = cnt_lo_hit[k] ? cnt_lo[k] : cnt_hi_hit[k] ? cnt_hi[k] : old;
         end
      endcase
   end
   assign csrRdata   = old;
   assign is_write   = (op == OP_RW) | ((op == OP_RS | op == OP_RC) & |csrWdata);
   assign csrIllegal = ((op != OP_NONE) & ~impl) | (read_only & is_write);
   assign wr_data    = op == OP_RW ? csrWdata : op == OP_RS ? (old | csrWdata) : (old & ~csrWdata);
   assign csr_we     = is_write & impl & ~read_only & ~commit & ~take_mret;
   // Only interrupts are vectored; mtvec[0] is already forced low when vectoring is off.
   assign trap_target = {mtvec[31:2], 2'b00} + ((commit_irq & mtvec[0]) ? {25'b0, commit_code, 2'b00} : 32'h0);
   always_comb begin
      state_next  = state;
      commit      = 1'b0;
      commit_irq  = 1'b0;
      take_mret   = 1'b0;
      latch       = 1'b0;
      commit_code = trapCause;
      commit_pc   = trapPC;
      commit_val  = trapVal;
      case (state)
         ST_RUN: begin
            if (trapReq) begin
               commit     = wbValid;
               latch      = ~wbValid;
               state_next = wbValid ? ST_REDIRECT : ST_PENDING;
            end else if (irqPending & wbValid) begin
               commit      = 1'b1;
               commit_irq  = 1'b1;
               commit_code = irq_code;
               commit_val  = '0;
               state_next  = ST_REDIRECT;
            end else if (mret) begin
               take_mret  = 1'b1;
               state_next = ST_REDIRECT;
            end
         end
         ST_PENDING: begin
            commit      = wbValid;
            commit_code = pend_cause;
            commit_pc   = pend_pc;
            commit_val  = pend_val;
            state_next  = wbValid ? ST_REDIRECT : ST_PENDING;
         end
         default: state_next = ST_RUN;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_RUN;
         mie_bit       <= 1'b0;
         mpie_bit      <= 1'b0;
         mie_reg       <= '0;
         mtvec         <= '0;
         mcountinhibit <= '0;
         mscratch      <= '0;
         mepc          <= '0;
         mcause        <= '0;
         mtval         <= '0;
         mip           <= '0;
         redirect_pc_q <= '0;
         pend_cause    <= '0;
         pend_pc       <= '0;
         pend_val      <= '0;
      end else begin
         state <= state_next;
         mip   <= {20'b0, extIrq, 3'b0, timerIrq, 3'b0, swIrq, 3'b0};
         if (latch) begin
            pend_cause <= trapCause;
            pend_pc    <= trapPC;
            pend_val   <= trapVal;
         end
         if (commit) begin
            mepc          <= commit_pc;
            mcause        <= {commit_irq, 26'b0, commit_code};
            mtval         <= commit_val;
            mpie_bit      <= mie_bit;
            mie_bit       <= 1'b0;
            redirect_pc_q <= trap_target;
         end else if (take_mret) begin
            mie_bit       <= mpie_bit;
            mpie_bit      <= 1'b1;
            redirect_pc_q <= mepc;
         end else if (csr_we) begin
            case (csrAddr)
               CSR_MSTATUS: begin
                  mie_bit  <= wr_data[MSTATUS_MIE];
                  mpie_bit <= wr_data[MSTATUS_MPIE];
               end
               CSR_MIE:           mie_reg <= wr_data & MIE_MASK;
               CSR_MTVEC:         mtvec <= wr_data & {30'h3FFF_FFFF, 1'b0, VECTORED_EN != 0};
               CSR_MCOUNTINHIBIT: mcountinhibit <= wr_data & ~32'h2;
               CSR_MSCRATCH:      mscratch <= wr_data;
               CSR_MEPC:          mepc <= wr_data;
               CSR_MCAUSE:        mcause <= wr_data;
               CSR_MTVAL:         mtval <= wr_data;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_machine_csr_unit.sv
// tb_machine_csr_unit: directed checks of CSR access, counters, interrupt and
// exception traps, MRET and reset abandonment.
module tb_machine_csr_unit;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] csrAddr = '0;
   logic [1:0]  csrOp = '0;
   logic [31:0] csrWdata = '0;
   logic [31:0] csrRdata;
   logic        csrIllegal;
   logic        retire = 1'b0;
   logic [3:0]  hpmEvent = '0;
   logic        swIrq = 1'b0, timerIrq = 1'b0, extIrq = 1'b0;
   logic        trapReq = 1'b0;
   logic [4:0]  trapCause = '0;
   logic [31:0] trapPC = '0, trapVal = '0;
   logic        wbValid = 1'b0, mret = 1'b0;
   logic        redirectValid, irqPending;
   logic [31:0] redirectPC;
   int total = 0;
   int bad = 0;

   machine_csr_unit dut (
      .clock(clock), .reset(reset), .csrAddr(csrAddr), .csrOp(csrOp), .csrWdata(csrWdata),
      .csrRdata(csrRdata), .csrIllegal(csrIllegal), .retire(retire), .hpmEvent(hpmEvent),
      .swIrq(swIrq), .timerIrq(timerIrq), .extIrq(extIrq), .trapReq(trapReq),
      .trapCause(trapCause), .trapPC(trapPC), .trapVal(trapVal), .wbValid(wbValid),
      .mret(mret), .redirectValid(redirectValid), .redirectPC(redirectPC), .irqPending(irqPending)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic csr_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      csrOp = op; csrAddr = a; csrWdata = d;
      tick;
      csrOp = 2'b00;
   endtask

   task automatic check_csr(input string tag, input logic [11:0] a, input logic [31:0] want);
      csrOp = 2'b00; csrAddr = a;
      #1;
      check(tag, csrRdata, want);
   endtask

   task automatic check_illegal(input string tag, input logic [1:0] op, input logic [11:0] a,
                                input logic [31:0] d, input logic want);
      csrOp = op; csrAddr = a; csrWdata = d;
      #1;
      check(tag, {31'b0, csrIllegal}, {31'b0, want});
      tick;
      csrOp = 2'b00;
   endtask

   initial begin
      tick; tick;
      reset = 1'b0;
      check("rst_redirect_valid", {31'b0, redirectValid}, 32'h0);
      check("rst_redirect_pc", redirectPC, 32'h0);
      check("rst_irq_pending", {31'b0, irqPending}, 32'h0);
      check_csr("rst_mstatus", 12'h300, 32'h0000_1800);
      check_csr("rst_misa", 12'h301, 32'h4000_0100);
      // mie set/clear and read-only misa
      csr_write(2'b10, 12'h304, 32'h888);
      check_csr("mie_rs", 12'h304, 32'h888);
      csr_write(2'b11, 12'h304, 32'h8);
      check_csr("mie_rc", 12'h304, 32'h880);
      check_illegal("misa_write_illegal", 2'b01, 12'h301, 32'h1234, 1'b1);
      check_csr("misa_unchanged", 12'h301, 32'h4000_0100);
      check_illegal("misa_rs_zero_legal", 2'b10, 12'h301, 32'h0, 1'b0);
      check_illegal("unimpl_illegal", 2'b01, 12'h7C0, 32'h1, 1'b1);
      check_illegal("mcycleh_legal", 2'b10, 12'hB80, 32'h0, 1'b0);
      csr_write(2'b01, 12'h305, 32'h1003);
      check_csr("mtvec_bit1_zero", 12'h305, 32'h1001);
      // vectored external interrupt
      csr_write(2'b01, 12'h304, 32'h800);
      extIrq = 1'b1;
      csr_write(2'b01, 12'h300, 32'h8);
      check("irq_pending", {31'b0, irqPending}, 32'h1);
      wbValid = 1'b1;
      tick;
      wbValid = 1'b0;
      check("irq_redirect_valid", {31'b0, redirectValid}, 32'h1);
      check("irq_redirect_pc", redirectPC, 32'h0000_102C);
      check_csr("irq_mcause", 12'h342, 32'h8000_000B);
      check_csr("irq_mstatus", 12'h300, 32'h0000_1880);
      tick;
      check("irq_pulse_end", {31'b0, redirectValid}, 32'h0);
      extIrq = 1'b0;
      csr_write(2'b01, 12'h300, 32'h8);
      // exception held pending until writeback
      trapReq = 1'b1; trapCause = 5'd2; trapPC = 32'h200; trapVal = 32'hDEAD;
      tick;
      trapCause = 5'd5; trapPC = 32'h999; trapVal = 32'h0;
      check("pend_no_redirect", {31'b0, redirectValid}, 32'h0);
      tick; tick;
      wbValid = 1'b1;
      tick;
      trapReq = 1'b0; wbValid = 1'b0;
      check("exc_redirect_valid", {31'b0, redirectValid}, 32'h1);
      check("exc_redirect_pc", redirectPC, 32'h0000_1000);
      check_csr("exc_mepc", 12'h341, 32'h200);
      check_csr("exc_mtval", 12'h343, 32'hDEAD);
      check_csr("exc_mcause", 12'h342, 32'h2);
      check_csr("exc_mstatus", 12'h300, 32'h0000_1880);
      tick;
      check("exc_pulse_end", {31'b0, redirectValid}, 32'h0);
      mret = 1'b1;
      tick;
      mret = 1'b0;
      check("mret_redirect_valid", {31'b0, redirectValid}, 32'h1);
      check("mret_redirect_pc", redirectPC, 32'h200);
      check_csr("mret_mstatus", 12'h300, 32'h0000_1888);
      tick;
      check("mret_pulse_end", {31'b0, redirectValid}, 32'h0);
      // counter carry, inhibit, minstret and hpm
      csr_write(2'b01, 12'hB80, 32'h0);
      csr_write(2'b01, 12'hB00, 32'hFFFF_FFFF);
      check_csr("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
      check_csr("mcycle_hi_zero", 12'hB80, 32'h0);
      tick;
      check_csr("mcycle_lo_wrap", 12'hB00, 32'h0);
      check_csr("mcycle_hi_carry", 12'hB80, 32'h1);
      csr_write(2'b01, 12'h320, 32'h1);
      csr_write(2'b01, 12'hB00, 32'h1234);
      tick; tick; tick;
      check_csr("mcycle_inhibited", 12'hB00, 32'h1234);
      check_csr("mcycle_hi_kept", 12'hB80, 32'h1);
      csr_write(2'b01, 12'h320, 32'h0);
      tick;
      check_csr("mcycle_resumed", 12'hB00, 32'h1235);
      csr_write(2'b01, 12'hB02, 32'h0);
      retire = 1'b1;
      tick; tick;
      retire = 1'b0;
      check_csr("minstret", 12'hB02, 32'h2);
      hpmEvent = 4'b0010;
      tick;
      hpmEvent = 4'b0000;
      check_csr("hpm4", 12'hB04, 32'h1);
      check_csr("hpm3", 12'hB03, 32'h0);
      // reset while pending abandons the trap
      trapReq = 1'b1; trapCause = 5'd4; trapPC = 32'h300; trapVal = 32'h77;
      tick;
      reset = 1'b1; wbValid = 1'b1;
      tick;
      check("rstpend_no_redirect", {31'b0, redirectValid}, 32'h0);
      check_csr("rstpend_mepc", 12'h341, 32'h0);
      reset = 1'b0; trapReq = 1'b0; wbValid = 1'b0;
      tick;
      check("rstpend_still_idle", {31'b0, redirectValid}, 32'h0);
      check_csr("rstpend_mstatus", 12'h300, 32'h0000_1800);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
